sm_muldiv: RTL

Iterative, parametrised multiply/divide unit with HI/LO result registers. It supports MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO and replaces the single-cycle combinational multiply path in the ALU. It sits beside the ALU and takes rs/rt operands from the register file. The core stalls on busy and reads hi/lo for MFHI/MFLO.

---
 rtl/sm_muldiv_pkg.sv | 35 +++
 rtl/sm_muldiv.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sm_muldiv_pkg.sv
// Operation and instruction function codes shared by the multiply/divide unit
// and the control decoder that feeds it.
package sm_muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_NONE  = 3'd7;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // MFHI/MFLO only read hi/lo, so they map to MD_NONE and never start the unit.
  function automatic logic [2:0] mdOpFromFunct(input logic [5:0] funct);
    case (funct)
      F_MULT:  return MD_MULT;
      F_MULTU: return MD_MULTU;
      F_DIV:   return MD_DIV;
      F_DIVU:  return MD_DIVU;
      F_MTHI:  return MD_MTHI;
      F_MTLO:  return MD_MTLO;
      default: return MD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sm_muldiv.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// One shared 2*WIDTH accumulator serves both shift-add multiply and restoring divide.
module sm_muldiv
  import sm_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         stateReg;
  logic [CNT_W-1:0]   cntReg;
  logic [2*WIDTH-1:0] accReg;
  logic [WIDTH-1:0]   opBReg;
  logic [WIDTH-1:0]   rawAReg;
  logic               isDivReg;
  logic               qNegReg;
  logic               rNegReg;
  logic               divZeroReg;
  logic               doneReg;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;

  logic               isIter;
  logic               isDivOp;
  logic               isSigned;
  logic               signA;
  logic               signB;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;

  assign isIter   = (op <= MD_DIVU);
  assign isDivOp  = (op == MD_DIV) || (op == MD_DIVU);
  assign isSigned = (op == MD_MULT) || (op == MD_DIV);
  assign signA    = isSigned & srcA[WIDTH-1];
  assign signB    = isSigned & srcB[WIDTH-1];
  assign absA     = signA ? -srcA : srcA;
  assign absB     = signB ? -srcB : srcB;

  // Multiply: low half holds the remaining multiplier bits, high half the partial product.
  logic [WIDTH:0]     mulSum;
  // Divide: high half holds the partial remainder, low half shifts dividend out / quotient in.
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divTrial;
  logic               divFits;
  logic [2*WIDTH-1:0] stepNext;

  assign mulSum   = {1'b0, accReg[2*WIDTH-1:WIDTH]} + (accReg[0] ? {1'b0, opBReg} : '0);
  assign divShift = {accReg[2*WIDTH-1:WIDTH], accReg[WIDTH-1]};
  assign divTrial = divShift - {1'b0, opBReg};
  assign divFits  = ~divTrial[WIDTH];
  assign stepNext = isDivReg
                  ? {(divFits ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0]), accReg[WIDTH-2:0], divFits}
                  : {mulSum, accReg[WIDTH-1:1]};

  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;
  logic [WIDTH-1:0]   hiFix;
  logic [WIDTH-1:0]   loFix;

  assign prodFix = qNegReg ? -accReg : accReg;
  assign quotFix = qNegReg ? -accReg[WIDTH-1:0] : accReg[WIDTH-1:0];
  assign remFix  = rNegReg ? -accReg[2*WIDTH-1:WIDTH] : accReg[2*WIDTH-1:WIDTH];
  // A zero divisor bypasses sign correction: hi returns the dividend exactly as supplied.
  assign hiFix   = isDivReg ? (divZeroReg ? rawAReg : remFix) : prodFix[2*WIDTH-1:WIDTH];
  assign loFix   = isDivReg ? (divZeroReg ? '1 : quotFix) : prodFix[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= IDLE;
      cntReg     <= '0;
      accReg     <= '0;
      opBReg     <= '0;
      rawAReg    <= '0;
      isDivReg   <= 1'b0;
      qNegReg    <= 1'b0;
      rNegReg    <= 1'b0;
      divZeroReg <= 1'b0;
      doneReg    <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (start) begin
            if (isIter) begin
              stateReg   <= CALC;
              cntReg     <= CNT_W'(WIDTH);
              accReg     <= {{WIDTH{1'b0}}, absA};
              opBReg     <= absB;
              rawAReg    <= srcA;
              isDivReg   <= isDivOp;
              qNegReg    <= signA ^ signB;
              rNegReg    <= signA;
              divZeroReg <= (srcB == '0);
            end else if (op == MD_MTHI) begin
              hiReg   <= srcA;
              doneReg <= 1'b1;
            end else if (op == MD_MTLO) begin
              loReg   <= srcA;
              doneReg <= 1'b1;
            end
          end
        end
        CALC: begin
          if (flush) begin
            stateReg <= IDLE;
          end else begin
            accReg <= stepNext;
            cntReg <= cntReg - CNT_W'(1);
            if (cntReg == CNT_W'(1)) begin
              stateReg <= FIX;
            end
          end
        end
        FIX: begin
          stateReg <= IDLE;
          if (!flush) begin
            hiReg   <= hiFix;
            loReg   <= loFix;
            doneReg <= 1'b1;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign busy = (stateReg != IDLE);
  assign done = doneReg;
  assign hi   = hiReg;
  assign lo   = loReg;

endmodule
